// File: rtl/snake_frame_scanner.sv
// Walks a captured snake body vector one segment per clock, building a 16x16
// occupancy map and flagging head/body collision and head/food hit.
module snake_frame_scanner #(
    parameter int MAX_SEG = 225,
    parameter int COORD_W = 4
) (
    input  logic                            slw_clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [8*MAX_SEG-1:0]            snake,
    input  logic [7:0]                      seg_count,
    input  logic [COORD_W-1:0]              xfood,
    input  logic [COORD_W-1:0]              yfood,
    input  logic [COORD_W-1:0]              query_x,
    input  logic [COORD_W-1:0]              query_y,
    output logic                            busy,
    output logic                            done,
    output logic                            collision,
    output logic                            food_hit,
    output logic [(1<<(2*COORD_W))-1:0]     occupancy,
    output logic                            cell_on
);

    localparam int SEG_W  = 8;
    localparam int CELL_W = 2 * COORD_W;
    localparam int CELLS  = 1 << CELL_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;

    logic [SEG_W*MAX_SEG-1:0]   r_snake;
    logic [7:0]                 r_len;
    logic [7:0]                 r_idx;
    logic [CELL_W-1:0]          r_food;
    logic [CELL_W-1:0]          r_head;
    logic                       r_collision;
    logic                       r_food_hit;
    logic                       r_cell_on;
    logic [CELLS-1:0]           r_occ;

    logic [CELLS-1:0]           w_occ_next;
    logic [7:0]                 w_len_in;
    logic [7:0]                 w_head_idx;
    logic [SEG_W-1:0]           w_head_seg;
    logic [SEG_W-1:0]           w_seg;
    logic [CELL_W-1:0]          w_seg_cell;
    logic                       w_capture;
    logic                       w_scan;
    logic                       w_last;

    assign w_capture  = (r_state == S_IDLE) && start;
    assign w_scan     = (r_state == S_SCAN);
    assign w_len_in   = (seg_count > 8'(MAX_SEG)) ? 8'(MAX_SEG) : seg_count;
    assign w_head_idx = (r_len == 8'd0) ? 8'd0 : (r_len - 8'd1);
    assign w_head_seg = r_snake[{w_head_idx, 3'b000} +: SEG_W];
    // The captured vector is shifted down each scan cycle, so the current segment is always the low byte.
    assign w_seg      = r_snake[SEG_W-1:0];
    assign w_seg_cell = {w_seg[4 +: COORD_W], w_seg[COORD_W-1:0]};
    assign w_last     = (r_idx == (r_len - 8'd1));

    always_ff @(posedge slw_clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy   = 1'b1;
                w_next = (r_len == 8'd0) ? S_DONE : S_SCAN;
            end
            S_SCAN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Each occupancy bit clears on capture and latches when the scanned segment lands on its cell.
    generate
        for (genvar gi = 0; gi < CELLS; gi++) begin : g_occ
            assign w_occ_next[gi] = w_capture ? 1'b0
                                  : (r_occ[gi] | (w_scan && (w_seg_cell == CELL_W'(gi))));
        end
    endgenerate

    always_ff @(posedge slw_clk or negedge reset) begin
        if (!reset) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_next;
        end
    end

    always_ff @(posedge slw_clk or negedge reset) begin
        if (!reset) begin
            r_snake     <= '0;
            r_len       <= 8'd0;
            r_idx       <= 8'd0;
            r_food      <= '0;
            r_head      <= '0;
            r_collision <= 1'b0;
            r_food_hit  <= 1'b0;
            r_cell_on   <= 1'b0;
        end else begin
            r_cell_on <= r_occ[{query_y, query_x}];
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_snake     <= snake;
                        r_len       <= w_len_in;
                        r_food      <= {yfood, xfood};
                        r_idx       <= 8'd0;
                        r_collision <= 1'b0;
                        r_food_hit  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_head <= {w_head_seg[4 +: COORD_W], w_head_seg[COORD_W-1:0]};
                end
                S_SCAN: begin
                    r_snake <= r_snake >> SEG_W;
                    r_idx   <= r_idx + 8'd1;
                    if (!w_last && (w_seg_cell == r_head)) begin
                        r_collision <= 1'b1;
                    end
                    if (w_last) begin
                        r_food_hit <= (r_head == r_food);
                    end
                end
                default: ;
            endcase
        end
    end

    assign collision = r_collision;
    assign food_hit  = r_food_hit;
    assign occupancy = r_occ;
    assign cell_on   = r_cell_on;

endmodule

// File: tb/tb_snake_frame_scanner.sv
// Directed bench for snake_frame_scanner: expected scan results are queued
// when a scan is started and compared when done pulses.
module tb_snake_frame_scanner;

    localparam int MAX_SEG = 225;

    logic                   slw_clk = 1'b0;
    logic                   reset   = 1'b0;
    logic                   start   = 1'b0;
    logic [8*MAX_SEG-1:0]   snake   = '0;
    logic [7:0]             seg_count = 8'd0;
    logic [3:0]             xfood   = 4'd0;
    logic [3:0]             yfood   = 4'd0;
    logic [3:0]             query_x = 4'd0;
    logic [3:0]             query_y = 4'd0;
    logic                   busy;
    logic                   done;
    logic                   collision;
    logic                   food_hit;
    logic [255:0]           occupancy;
    logic                   cell_on;

    snake_frame_scanner #(.MAX_SEG(MAX_SEG), .COORD_W(4)) dut (
        .slw_clk   (slw_clk),
        .reset     (reset),
        .start     (start),
        .snake     (snake),
        .seg_count (seg_count),
        .xfood     (xfood),
        .yfood     (yfood),
        .query_x   (query_x),
        .query_y   (query_y),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .food_hit  (food_hit),
        .occupancy (occupancy),
        .cell_on   (cell_on)
    );

    always #5 slw_clk = ~slw_clk;

    typedef struct {
        int           lat;
        logic [255:0] occ;
        logic         coll;
        logic         food;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [7:0]  tb_segs [MAX_SEG];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge slw_clk);
        #1;
    endtask

    task automatic run_scan(input string name, input int cnt, input logic [3:0] fx,
                            input logic [3:0] fy, input bit mid_start);
        exp_t       e;
        int         len;
        int         cyc;
        int         extra;
        bit         got;
        logic [7:0] head;
        len    = (cnt > MAX_SEG) ? MAX_SEG : cnt;
        e.occ  = '0;
        e.coll = 1'b0;
        e.food = 1'b0;
        e.lat  = len + 2;
        if (len > 0) begin
            head = tb_segs[len-1];
            for (int i = 0; i < len; i++) begin
                e.occ[int'(tb_segs[i][7:4]) * 16 + int'(tb_segs[i][3:0])] = 1'b1;
                if (i < len - 1 && tb_segs[i] == head) e.coll = 1'b1;
            end
            e.food = (head[3:0] == fx) && (head[7:4] == fy);
        end
        sb.push_back(e);

        for (int i = 0; i < MAX_SEG; i++) snake[i*8 +: 8] = tb_segs[i];
        seg_count = cnt[7:0];
        xfood     = fx;
        yfood     = fy;
        start     = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 400) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                check({name, "_busy_load"}, busy, 1'b1);
                // Scramble live inputs: only the captured copy may be scanned.
                for (int i = 0; i < MAX_SEG; i++) snake[i*8 +: 8] = 8'($urandom);
                seg_count = 8'($urandom);
                xfood     = 4'($urandom);
                yfood     = 4'($urandom);
            end
            if (mid_start && cyc == 3) start = 1'b1;
            if (mid_start && cyc == 4) start = 1'b0;
            if (done) got = 1'b1;
        end
        check({name, "_done_seen"}, got, 1'b1);
        e = sb.pop_front();
        if (got) begin
            check({name, "_latency"}, cyc, e.lat);
            check({name, "_busy_at_done"}, busy, 1'b0);
            check({name, "_occupancy"}, occupancy, e.occ);
            check({name, "_collision"}, collision, e.coll);
            check({name, "_food_hit"}, food_hit, e.food);
            extra = 0;
            repeat (8) begin
                tick();
                if (done) extra++;
            end
            check({name, "_extra_done"}, extra, 0);
            check({name, "_occ_hold"}, occupancy, e.occ);
        end
        $display("txn %s len=%0d latency=%0d coll=%0b food=%0b", name, len, cyc, collision, food_hit);
    endtask

    initial begin
        for (int i = 0; i < MAX_SEG; i++) tb_segs[i] = 8'h00;

        reset = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_collision", collision, 1'b0);
        check("rst_food_hit", food_hit, 1'b0);
        check("rst_occupancy", occupancy, 256'd0);
        check("rst_cell_on", cell_on, 1'b0);
        reset = 1'b1;
        tick();

        // Straight snake along y=1, food elsewhere
        tb_segs[0] = 8'h11; tb_segs[1] = 8'h12; tb_segs[2] = 8'h13;
        run_scan("basic", 3, 4'd3, 4'd3, 1'b0);

        // Head lands on food
        tb_segs[0] = 8'h13; tb_segs[1] = 8'h23; tb_segs[2] = 8'h33;
        run_scan("food", 3, 4'd3, 4'd3, 1'b0);

        // Head re-enters the tail cell; a second start mid-scan must be ignored
        tb_segs[0] = 8'h22; tb_segs[1] = 8'h23; tb_segs[2] = 8'h33;
        tb_segs[3] = 8'h32; tb_segs[4] = 8'h22;
        run_scan("collide", 5, 4'd0, 4'd0, 1'b1);
        check("collide_popcount", $countones(occupancy), 4);

        run_scan("empty", 0, 4'd1, 4'd1, 1'b0);

        for (int i = 0; i < MAX_SEG; i++) tb_segs[i] = 8'($urandom);
        run_scan("full", 255, 4'd7, 4'd9, 1'b0);

        // Reset in the middle of a scan
        for (int i = 0; i < 10; i++) tb_segs[i] = 8'(8'h40 + i);
        for (int i = 0; i < MAX_SEG; i++) snake[i*8 +: 8] = tb_segs[i];
        seg_count = 8'd10;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        begin
            logic [255:0] part;
            part = '0;
            part[int'(tb_segs[0][7:4]) * 16 + int'(tb_segs[0][3:0])] = 1'b1;
            part[int'(tb_segs[1][7:4]) * 16 + int'(tb_segs[1][3:0])] = 1'b1;
            check("midscan_partial_occ", occupancy, part);
        end
        check("midscan_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_occupancy", occupancy, 256'd0);
        check("midrst_collision", collision, 1'b0);
        tick();
        reset = 1'b1;
        begin
            int nd;
            nd = 0;
            repeat (20) begin
                tick();
                if (done) nd++;
            end
            check("midrst_no_done", nd, 0);
        end
        $display("txn midreset busy=%0b occ_zero=%0b", busy, occupancy == 256'd0);

        // Wrapped cell (15,0) plus origin
        tb_segs[0] = 8'h00; tb_segs[1] = 8'h0F;
        run_scan("wrap", 2, 4'd5, 4'd5, 1'b0);
        check("wrap_bit15", occupancy[15], 1'b1);
        query_x = 4'd15;
        query_y = 4'd0;
        tick();
        check("query_15_0", cell_on, 1'b1);
        query_x = 4'd14;
        tick();
        check("query_14_0", cell_on, 1'b0);
        $display("txn query cell_on=%0b", cell_on);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
